// File: rtl/vga_timing_monitor_if.sv
// -----------------------------------------------------------------------------
// vga_timing_monitor_if
// Video output bundle of a VGA source as seen by a passive monitor.
//   vga_hs    : horizontal sync, active low
//   vga_vs    : vertical sync, active low
//   vga_blank : high during active pixels
//   vga_rgb   : pixel colour, meaningful only while vga_blank is high
// master drives the stream (video source / bench), slave only observes it.
// -----------------------------------------------------------------------------
interface vga_timing_monitor_if;
  logic        vga_hs;
  logic        vga_vs;
  logic        vga_blank;
  logic [23:0] vga_rgb;

  modport master (output vga_hs, vga_vs, vga_blank, vga_rgb);
  modport slave  (input  vga_hs, vga_vs, vga_blank, vga_rgb);
endinterface

// File: rtl/vga_timing_monitor.sv
// -----------------------------------------------------------------------------
// vga_timing_monitor
// Passive checker in the pixel clock domain. Locks onto a VGA stream, measures
// line/frame geometry against the programmed timing, raises sticky error flags
// and produces a per-frame checksum of the active pixels.
// Ports:
//   pixel_clk, pixel_rst_n : clock, asynchronous active-low reset
//   vga (slave)            : observed HS/VS/BLANK/RGB
//   i_clr_err              : synchronous clear of the sticky error flags
//   o_locked               : two consecutive clean frames seen
//   o_err_h/o_err_v/o_err_blank : sticky horizontal/vertical/active-window errors
//   o_frame_cnt            : clean frames since reset (wraps)
//   o_frame_sum(_valid)    : checksum of last clean frame, one-cycle update pulse
//   o_line_len             : last HS fall-to-fall period in pixels
//   o_frame_lines          : last clean VS period in lines
// -----------------------------------------------------------------------------
module vga_timing_monitor #(
  parameter int HDISP  = 800,
  parameter int VDISP  = 480,
  parameter int HFP    = 40,
  parameter int HPULSE = 48,
  parameter int HBP    = 40,
  parameter int VFP    = 13,
  parameter int VPULSE = 3,
  parameter int VBP    = 29
) (
  input  logic                       pixel_clk,
  input  logic                       pixel_rst_n,
  vga_timing_monitor_if.slave        vga,
  input  logic                       i_clr_err,
  output logic                       o_locked,
  output logic                       o_err_h,
  output logic                       o_err_v,
  output logic                       o_err_blank,
  output logic [15:0]                o_frame_cnt,
  output logic [31:0]                o_frame_sum,
  output logic                       o_frame_sum_valid,
  output logic [11:0]                o_line_len,
  output logic [10:0]                o_frame_lines
);

  localparam logic [11:0] HTOTAL     = 12'(HPULSE + HBP + HDISP + HFP);
  localparam logic [11:0] HSYNC_W    = 12'(HPULSE);
  localparam logic [11:0] HACT_START = 12'(HPULSE + HBP);
  localparam logic [11:0] HACT_LEN   = 12'(HDISP);
  localparam logic [10:0] VTOTAL     = 11'(VPULSE + VBP + VDISP + VFP);
  localparam logic [10:0] VSYNC_W    = 11'(VPULSE);
  localparam logic [10:0] VACT_FIRST = 11'(VPULSE + VBP);
  localparam logic [10:0] VACT_LAST  = 11'(VPULSE + VBP + VDISP - 1);

  localparam logic [0:0] ST_SEARCH = 1'b0;
  localparam logic [0:0] ST_TRACK  = 1'b1;

  logic        r_hs1, r_vs1, r_blank1, r_hs2, r_vs2, r_blank2;
  logic [23:0] r_rgb1;
  logic [11:0] r_hcnt, r_run;
  logic [10:0] r_vcnt;
  logic        r_line_act;
  logic [31:0] r_acc;
  logic [0:0]  r_state;
  logic [1:0]  r_good;

  logic        w_hs_fall, w_hs_rise, w_vs_fall, w_vs_rise, w_blank_rise, w_blank_fall;
  logic [11:0] w_hpos, w_hcnt_next, w_run_next;
  logic [10:0] w_vcnt_inc, w_vline;
  logic        w_in_win, w_prev_in_win, w_line_act_next;
  logic [31:0] w_acc_next;
  logic        w_eh, w_ev, w_eb, w_track, w_err_any;
  logic [1:0]  w_good_next;

  // Edges are S1 versus previous S1; hpos/vline give this cycle's position
  // (a fall is position/line 0 in the same cycle it is seen).
  assign w_hs_fall    =  r_hs2 & ~r_hs1;
  assign w_hs_rise    = ~r_hs2 &  r_hs1;
  assign w_vs_fall    =  r_vs2 & ~r_vs1;
  assign w_vs_rise    = ~r_vs2 &  r_vs1;
  assign w_blank_rise = ~r_blank2 &  r_blank1;
  assign w_blank_fall =  r_blank2 & ~r_blank1;

  assign w_hpos      = w_hs_fall ? 12'd0 : r_hcnt;
  assign w_hcnt_next = w_hs_fall ? 12'd1 : ((r_hcnt == 12'hFFF) ? r_hcnt : r_hcnt + 12'd1);
  assign w_vcnt_inc  = (r_vcnt == 11'h7FF) ? r_vcnt : r_vcnt + 11'd1;
  assign w_vline     = w_vs_fall ? 11'd0 : (w_hs_fall ? w_vcnt_inc : r_vcnt);
  // Run length of the current blank-high stretch; held after the fall so it can be checked.
  assign w_run_next  = r_blank1 ? (w_blank_rise ? 12'd1 : ((r_run == 12'hFFF) ? r_run : r_run + 12'd1))
                                : r_run;
  assign w_line_act_next = w_hs_fall ? r_blank1 : (r_line_act | r_blank1);

  assign w_in_win      = (w_vline >= VACT_FIRST) && (w_vline <= VACT_LAST);
  assign w_prev_in_win = (r_vcnt >= VACT_FIRST) && (r_vcnt <= VACT_LAST);
  assign w_acc_next    = r_acc + (r_blank1 ? {8'h00, r_rgb1} : 32'h0000_0000);

  assign w_eh = (w_hs_rise && (w_hpos != HSYNC_W)) ||
                (w_hs_fall && (r_hcnt != HTOTAL));
  assign w_eb = (w_blank_rise && (w_hpos != HACT_START)) ||
                (w_blank_fall && (r_run != HACT_LEN)) ||
                (r_blank1 && !w_in_win) ||
                (w_hs_fall && w_prev_in_win && !r_line_act);
  // VS must rise exactly on the HS fall that opens line VSYNC_W, and fall on an HS fall.
  assign w_ev = (w_vs_fall && !w_hs_fall) ||
                (w_vs_fall && (w_vcnt_inc != VTOTAL)) ||
                (w_vs_rise && !(w_hs_fall && (w_vline == VSYNC_W))) ||
                (w_hs_fall && !r_vs1 && (w_vline == VSYNC_W));

  assign w_track     = (r_state == ST_TRACK);
  assign w_err_any   = w_eh | w_ev | w_eb;
  assign w_good_next = (r_good == 2'd2) ? 2'd2 : r_good + 2'd1;

  // S1 input capture plus previous-S1 copy for edge detection.
  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      r_hs1    <= 1'b1;
      r_vs1    <= 1'b1;
      r_blank1 <= 1'b0;
      r_rgb1   <= 24'h00_0000;
      r_hs2    <= 1'b1;
      r_vs2    <= 1'b1;
      r_blank2 <= 1'b0;
    end else begin
      r_hs1    <= vga.vga_hs;
      r_vs1    <= vga.vga_vs;
      r_blank1 <= vga.vga_blank;
      r_rgb1   <= vga.vga_rgb;
      r_hs2    <= r_hs1;
      r_vs2    <= r_vs1;
      r_blank2 <= r_blank1;
    end
  end

  // Position counters run in every state so TRACK starts with valid geometry.
  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      r_hcnt     <= 12'd0;
      r_vcnt     <= 11'd0;
      r_run      <= 12'd0;
      r_line_act <= 1'b0;
      o_line_len <= 12'd0;
    end else begin
      r_hcnt     <= w_hcnt_next;
      r_vcnt     <= w_vline;
      r_run      <= w_run_next;
      r_line_act <= w_line_act_next;
      o_line_len <= w_hs_fall ? r_hcnt : o_line_len;
    end
  end

  // Lock state machine, checksum accumulator and per-frame results.
  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      r_state           <= ST_SEARCH;
      r_good            <= 2'd0;
      r_acc             <= 32'h0000_0000;
      o_locked          <= 1'b0;
      o_frame_cnt       <= 16'd0;
      o_frame_sum       <= 32'h0000_0000;
      o_frame_sum_valid <= 1'b0;
      o_frame_lines     <= 11'd0;
    end else begin
      o_frame_sum_valid <= 1'b0;
      case (r_state)
        ST_SEARCH: begin
          o_locked <= 1'b0;
          if (w_vs_fall) begin
            r_state <= ST_TRACK;
            r_good  <= 2'd0;
            r_acc   <= 32'h0000_0000;
          end else begin
            r_acc   <= w_acc_next;
          end
        end
        ST_TRACK: begin
          if (w_err_any) begin
            r_state  <= ST_SEARCH;
            r_good   <= 2'd0;
            o_locked <= 1'b0;
            r_acc    <= 32'h0000_0000;
          end else if (w_vs_fall) begin
            o_frame_cnt       <= o_frame_cnt + 16'd1;
            o_frame_sum       <= w_acc_next;
            o_frame_sum_valid <= 1'b1;
            o_frame_lines     <= w_vcnt_inc;
            r_acc             <= 32'h0000_0000;
            r_good            <= w_good_next;
            o_locked          <= (w_good_next == 2'd2);
          end else begin
            r_acc <= w_acc_next;
          end
        end
        default: begin
          r_state  <= ST_SEARCH;
          r_good   <= 2'd0;
          o_locked <= 1'b0;
          r_acc    <= 32'h0000_0000;
        end
      endcase
    end
  end

  // Sticky error flags; a clear loses against an error detected in the same cycle.
  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      o_err_h     <= 1'b0;
      o_err_v     <= 1'b0;
      o_err_blank <= 1'b0;
    end else begin
      o_err_h     <= (i_clr_err ? 1'b0 : o_err_h)     | (w_track & w_eh);
      o_err_v     <= (i_clr_err ? 1'b0 : o_err_v)     | (w_track & w_ev);
      o_err_blank <= (i_clr_err ? 1'b0 : o_err_blank) | (w_track & w_eb);
    end
  end

endmodule

// File: doc/vga_timing_monitor.md
# vga_timing_monitor

Passive checker on the pixel clock domain that sits on the receiving end of the VGA controller's video output. It watches HS, VS, BLANK and RGB and locks onto the stream. It measures line and frame geometry against the programmed timing and raises sticky error flags on any deviation. It also produces a per-frame pixel checksum, so benches and on-board debug can confirm that the video source emits the expected frame.

## Interface
- HDISP, 800, active pixels per line
- VDISP, 480, active lines per frame
- HFP, 40, horizontal front porch (pixels)
- HPULSE, 48, HS low width (pixels)
- HBP, 40, horizontal back porch (pixels)
- VFP, 13, vertical front porch (lines)
- VPULSE, 3, VS low width (lines)
- VBP, 29, vertical back porch (lines)
- pixel_clk  in  1  sole clock; all inputs sampled, all outputs driven on its rising edge
- pixel_rst_n  in  1  asynchronous, active-low reset
- vga_hs  in  1  horizontal sync, active low
- vga_vs  in  1  vertical sync, active low
- vga_blank  in  1  high = active pixel
- vga_rgb  in  24  pixel colour, meaningful only when vga_blank=1
- clr_err  in  1  synchronous clear of the sticky error flags
- locked  out  1  stream verified good
- err_h  out  1  sticky horizontal timing error
- err_v  out  1  sticky vertical timing error
- err_blank  out  1  sticky active-window error
- frame_cnt  out  16  frames seen since reset, wraps at 2^16
- frame_sum  out  32  checksum of the last completed frame
- frame_sum_valid  out  1  one-cycle pulse when frame_sum updates
- line_len  out  12  last measured HS period, in pixels
- frame_lines  out  11  last measured VS period, in lines

## Operation
- Register all video inputs once (stage S1). Detect edges by comparing S1 with the previous S1 value.
- HTOTAL = HPULSE+HBP+HDISP+HFP. VTOTAL = VPULSE+VBP+VDISP+VFP.
- Pixel counter hcnt counts cycles since the last HS falling edge; position 0 is the cycle the fall is seen.
- Line counter vcnt increments at each HS fall and clears to 0 at a VS fall. Line 0 is the line in which VS falls.
- Arithmetic:
  - Counters saturate at their maximum.
  - frame_sum accumulates modulo 2^32 of {8'h00, vga_rgb} over cycles with S1 blank=1.
- State machine:
  - SEARCH: no checking, locked=0. On a VS fall, clear the accumulators, set good_frames=0 and go to TRACK.
  - TRACK: apply every check below. Any check failure sets its flag, clears locked and returns to SEARCH on the same cycle.
  - At each VS fall in TRACK with no failure in the frame: frame_cnt++, latch frame_sum, pulse frame_sum_valid, latch frame_lines, clear the accumulator, good_frames++ (saturating at 2).
  - locked=1 while good_frames==2.
- err_h conditions:
  - HS low width ≠ HPULSE.
  - HS fall-to-fall period ≠ HTOTAL; line_len is updated at every HS fall regardless.
- err_blank conditions:
  - blank rises at an hcnt other than HPULSE+HBP.
  - blank high run ≠ HDISP cycles.
  - blank high on a line outside [VPULSE+VBP, VPULSE+VBP+VDISP-1].
  - a line in that window carries no active run.
- err_v conditions:
  - VS low width ≠ VPULSE lines (VS rise must coincide with the HS fall of line VPULSE).
  - VS fall not on the same cycle as an HS fall.
  - VS period ≠ VTOTAL lines.
- clr_err clears all three flags. An error detected in the same cycle wins, and its flag stays set.

## Timing
- Reset values:
  - All outputs 0, state SEARCH.
  - Counters 0.
  - S1 regs reset to hs=1, vs=1, blank=0.
- Latency:
  - Error flags assert 2 cycles after the offending input edge or count (S1 + check register).
  - frame_sum, frame_sum_valid, frame_cnt, frame_lines and locked update 2 cycles after the VS falling input.
- Error timing:
  - The first complete frame after SEARCH is checked, but a partial frame is never checked.
  - An error during the VS-fall cycle discards that frame: no frame_sum_valid, and frame_cnt is unchanged.
- Reset asserted mid-frame: immediate clear. After release, the monitor resynchronises at the next VS fall.
- frame_cnt wraps 65535→0 without affecting locked.

## Test plan
- Nominal stream with defaults (HTOTAL=928, VTOTAL=525), 4 frames -> locked=1 after the 3rd VS fall, no error flags, line_len=928, frame_lines=525, frame_cnt=3.
- Constant RGB 24'h000001 -> frame_sum=384000 (800×480) on every frame_sum_valid pulse.
- One line with HS low width 47 -> err_h=1, locked=0. Relock 2 good frames later. clr_err then drops err_h.
- blank asserted for 801 cycles on line 100 -> err_blank=1, no frame_sum_valid for that frame.
- VS period 524 lines -> err_v=1, frame_lines not updated.
- Reset pulse mid-frame, then clr_err asserted on the same cycle as a new HS error -> all outputs 0 during reset. After reset, err_h remains 1.
